// File: rtl/fetch_stage0_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, bundle field
// positions and the default reset PC.
package fetch_stage0_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam int BND_VALID = 32;
  localparam int BND_PC_HI = 31;
  localparam int BND_PC_LO = 16;
  localparam int BND_RI_HI = 15;
  localparam int BND_RI_LO = 8;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/fetch_stage0_pc_unit.sv
// Program counter: redirect load beats increment; arithmetic wraps modulo
// 2^ADDR_W.
module pc_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_r;

  // PC register with synchronous clear, redirect load and increment
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= target;
    end else if (inc) begin
      pc_r <= pc_r + ADDR_W'(1);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_stage0.sv
// Instruction fetch stage: req/ack fetch FSM, one-entry output buffer feeding
// the stage 0/1 register, with stall, branch redirect and run/halt gating.
module fetch_stage0
  import fetch_stage0_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      run,
  input  logic                      stall,
  input  logic                      br_taken,
  input  logic [ADDR_W-1:0]         br_target,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic                      imem_ack,
  input  logic [INSTR_W-1:0]        imem_data,
  output logic [ADDR_W+INSTR_W:0]   bundle,
  output logic                      c_left
);

  localparam int BW = 1 + ADDR_W + INSTR_W;
  localparam int VB = BW - 1;

  fetch_state_e      state_r, state_s;
  logic [BW-1:0]     bundle_r, bundle_s;
  logic [ADDR_W-1:0] drain_addr_r, drain_addr_s;
  logic [ADDR_W-1:0] pc_s;
  logic              pc_load_s, pc_inc_s;
  logic              req_s;
  logic [ADDR_W-1:0] addr_s;
  logic              c_ok_s, go_s;

  pc_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk   (clk),
    .clr   (clr),
    .load  (pc_load_s),
    .target(br_target),
    .inc   (pc_inc_s),
    .pc    (pc_s)
  );

  // c_ok_s ignores redirect so an outstanding request is not dropped by br_taken
  assign c_ok_s = bundle_r[VB] & ~stall;
  assign go_s   = ~bundle_r[VB] | c_ok_s;
  assign c_left = c_ok_s & ~br_taken;

  // Next-state, buffer update and memory request decode
  always_comb begin
    state_s      = state_r;
    bundle_s     = bundle_r;
    drain_addr_s = drain_addr_r;
    pc_load_s    = 1'b0;
    pc_inc_s     = 1'b0;
    req_s        = 1'b0;
    addr_s       = pc_s;

    if (c_left) begin
      bundle_s[VB] = 1'b0;
    end else begin
      bundle_s[VB] = bundle_r[VB];
    end

    case (state_r)
      S_IDLE: begin
        if (br_taken) begin
          pc_load_s    = 1'b1;
          bundle_s[VB] = 1'b0;
          state_s      = run ? S_FETCH : S_IDLE;
        end else if (run) begin
          state_s = go_s ? S_FETCH : S_HOLD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        req_s = go_s;
        if (br_taken) begin
          pc_load_s    = 1'b1;
          bundle_s[VB] = 1'b0;
          // Only a request still in flight needs draining
          if (imem_ack || !go_s) begin
            state_s = S_FETCH;
          end else begin
            state_s      = S_DRAIN;
            drain_addr_s = pc_s;
          end
        end else if (!go_s) begin
          state_s = S_HOLD;
        end else if (imem_ack) begin
          bundle_s = {1'b1, pc_s, imem_data};
          pc_inc_s = 1'b1;
          state_s  = run ? S_FETCH : S_IDLE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          pc_load_s    = 1'b1;
          bundle_s[VB] = 1'b0;
          state_s      = run ? S_FETCH : S_IDLE;
        end else if (c_left) begin
          state_s = run ? S_FETCH : S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      S_DRAIN: begin
        req_s  = 1'b1;
        addr_s = drain_addr_r;
        if (br_taken) begin
          pc_load_s    = 1'b1;
          bundle_s[VB] = 1'b0;
        end else begin
          pc_load_s = 1'b0;
        end
        if (imem_ack) begin
          state_s = run ? S_FETCH : S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, output buffer and drain address registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r      <= S_IDLE;
      bundle_r     <= '0;
      drain_addr_r <= '0;
    end else begin
      state_r      <= state_s;
      bundle_r     <= bundle_s;
      drain_addr_r <= drain_addr_s;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = addr_s;
  assign bundle    = bundle_r;

endmodule

// File: tb/tb_fetch_stage0.sv
// Directed self-checking bench for fetch_stage0 with a simple memory model:
// data = 16'h1000 + addr, except 0x0003 -> ABCD and 0x0007 -> DEAD.
module tb_fetch_stage0;
  import fetch_stage0_pkg::*;

  logic        clk = 1'b0;
  logic        clr, run, stall, br_taken;
  logic [15:0] br_target;
  logic        imem_req, imem_ack, c_left;
  logic [15:0] imem_addr, imem_data;
  logic [32:0] bundle;
  logic        auto_ack, man_ack;
  logic        dead_seen = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_stage0 dut (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .stall    (stall),
    .br_taken (br_taken),
    .br_target(br_target),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .imem_ack (imem_ack),
    .imem_data(imem_data),
    .bundle   (bundle),
    .c_left   (c_left)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0003: mem_word = 16'hABCD;
      16'h0007: mem_word = 16'hDEAD;
      default:  mem_word = 16'h1000 + a;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign imem_ack  = auto_ack ? imem_req : man_ack;

  always @(posedge clk) begin
    if (bundle[BND_VALID] && bundle[15:0] == 16'hDEAD) dead_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    auto_ack = 1'b0; man_ack = 1'b0;
    step(); step();
    clr = 1'b0; #1;
    chk("rst_bundle", bundle, 33'd0);
    chk("rst_cleft", 33'(c_left), 33'd0);
    chk("rst_req", 33'(imem_req), 33'd0);

    // Streaming with same-cycle ack
    run = 1'b1; auto_ack = 1'b1;
    step();
    chk("t1_req", 33'(imem_req), 33'd1);
    chk("t1_addr0", 33'(imem_addr), 33'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_bundle", bundle, {1'b1, 16'(i), 16'(32'h1000 + i)});
      chk("t1_cleft", 33'(c_left), 33'd1);
    end

    // Stall holds the buffer and blocks requests
    step();
    chk("t3_bundle", bundle, {1'b1, 16'h0003, 16'hABCD});
    stall = 1'b1; #1;
    chk("t3_cleft", 33'(c_left), 33'd0);
    chk("t3_req", 33'(imem_req), 33'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold", bundle, {1'b1, 16'h0003, 16'hABCD});
      chk("t3_hold_cleft", 33'(c_left), 33'd0);
      chk("t3_hold_req", 33'(imem_req), 33'd0);
    end
    stall = 1'b0; #1;
    chk("t3_release", 33'(c_left), 33'd1);
    step();
    chk("t3_resume_req", 33'(imem_req), 33'd1);
    chk("t3_resume_addr", 33'(imem_addr), 33'h0004);
    chk("t3_empty", 33'(bundle[BND_VALID]), 33'd0);

    // Ack delayed by 3 cycles at pc=5
    step();
    chk("t2_prev", bundle, {1'b1, 16'h0004, 16'h1004});
    auto_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      man_ack = (i == 3); #1;
      chk("t2_req", 33'(imem_req), 33'd1);
      chk("t2_addr", 33'(imem_addr), 33'h0005);
      if (i >= 1) chk("t2_wait_empty", 33'(bundle[BND_VALID]), 33'd0);
      step();
    end
    man_ack = 1'b0; #1;
    chk("t2_bundle", bundle, {1'b1, 16'h0005, 16'h1005});
    chk("t2_next_addr", 33'(imem_addr), 33'h0006);

    // Redirect with a request outstanding at 0x0007
    auto_ack = 1'b1;
    step();
    chk("t4_prev", bundle, {1'b1, 16'h0006, 16'h1006});
    auto_ack = 1'b0; br_taken = 1'b1; br_target = 16'h0040; #1;
    chk("t4_br_cleft", 33'(c_left), 33'd0);
    chk("t4_br_addr", 33'(imem_addr), 33'h0007);
    step();
    br_taken = 1'b0; #1;
    chk("t4_flush", 33'(bundle[BND_VALID]), 33'd0);
    chk("t4_drain_req", 33'(imem_req), 33'd1);
    chk("t4_drain_addr", 33'(imem_addr), 33'h0007);
    step();
    man_ack = 1'b1; #1;
    chk("t4_drain_addr2", 33'(imem_addr), 33'h0007);
    step();
    man_ack = 1'b0; #1;
    chk("t4_discard", 33'(bundle[BND_VALID]), 33'd0);
    chk("t4_target_req", 33'(imem_req), 33'd1);
    chk("t4_target_addr", 33'(imem_addr), 33'h0040);
    auto_ack = 1'b1;
    step();
    chk("t4_bundle", bundle, {1'b1, 16'h0040, 16'h1040});

    // PC wrap at 0xFFFF (redirect with same-cycle ack gets there)
    br_taken = 1'b1; br_target = 16'hFFFF;
    step();
    br_taken = 1'b0; #1;
    chk("t5_addr", 33'(imem_addr), 33'h0FFFF);
    chk("t5_flush", 33'(bundle[BND_VALID]), 33'd0);
    step();
    chk("t5_bundle", bundle, {1'b1, 16'hFFFF, 16'h0FFF});
    chk("t5_wrap", 33'(imem_addr), 33'h0000);

    // Clear while holding under stall; late ack ignored
    step();
    chk("t6_prev", bundle, {1'b1, 16'h0000, 16'h1000});
    stall = 1'b1; #1;
    chk("t6_gate", 33'(imem_req), 33'd0);
    step();
    chk("t6_hold", bundle, {1'b1, 16'h0000, 16'h1000});
    clr = 1'b1; run = 1'b0;
    step();
    clr = 1'b0; auto_ack = 1'b0; man_ack = 1'b1; #1;
    chk("t6_bundle", bundle, 33'd0);
    chk("t6_cleft", 33'(c_left), 33'd0);
    chk("t6_req", 33'(imem_req), 33'd0);
    step();
    chk("t6_late_ack", bundle, 33'd0);
    man_ack = 1'b0; stall = 1'b0; run = 1'b1;
    step();
    chk("t6_req_after", 33'(imem_req), 33'd1);
    chk("t6_reset_pc", 33'(imem_addr), 33'(RESET_PC_DEF));

    chk("dead_never_seen", 33'(dead_seen), 33'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
